// File: rtl/ipsxe_floating_point_fl2fl_classify_v2_0.sv
// ipsxe_floating_point_fl2fl_classify_v2_0
// Two-stage, multi-lane classifier for packed IEEE-style operands feeding the
// fl2fl rounding/packing stage. Each lane is split into sign, class, unbiased
// exponent and fraction. The block also raises target-format overflow/underflow
// flags and keeps sticky exception flags.
// Optional feature macro: IPSXE_FLT_FL2FL_SUBNORM_EN. When it is defined,
// subnormals are normalised. When it is undefined, they are flushed to zero.
module ipsxe_floating_point_fl2fl_classify_v2_0 #(
    parameter int FLOAT_IN_EXP  = 8,
    parameter int FLOAT_IN_FRAC = 24,
    parameter int FLOAT_OUT_EXP = 11,
    parameter int CHANNELS      = 2
) (
    input  logic                                            i_aclk,
    input  logic                                            i_areset,
    input  logic                                            i_aclken,
    input  logic                                            s_axis_tvalid,
    output logic                                            s_axis_tready,
    input  logic [CHANNELS*(FLOAT_IN_EXP+FLOAT_IN_FRAC)-1:0] s_axis_tdata,
    output logic                                            m_axis_tvalid,
    input  logic                                            m_axis_tready,
    output logic [CHANNELS-1:0]                             m_sign,
    output logic [3*CHANNELS-1:0]                           m_class,
    output logic [(FLOAT_IN_EXP+2)*CHANNELS-1:0]            m_exp,
    output logic [(FLOAT_IN_FRAC-1)*CHANNELS-1:0]           m_frac,
    output logic [CHANNELS-1:0]                             m_overflow,
    output logic [CHANNELS-1:0]                             m_underflow,
    output logic [CHANNELS-1:0]                             m_invalid,
    input  logic                                            i_flag_clr,
    output logic [3:0]                                      o_sticky_flags
);

    localparam int IW       = FLOAT_IN_EXP + FLOAT_IN_FRAC;
    localparam int EW       = FLOAT_IN_EXP + 2;
    localparam int FW       = FLOAT_IN_FRAC - 1;
    localparam int BIAS_IN  = 2**(FLOAT_IN_EXP-1) - 1;
    localparam int BIAS_OUT = 2**(FLOAT_OUT_EXP-1) - 1;
    localparam logic FLAGS_EN = (FLOAT_IN_EXP > FLOAT_OUT_EXP);
    localparam logic [31:0] OVF_TH = 32'(BIAS_IN + BIAS_OUT);
    localparam logic [31:0] UNF_TH = 32'(BIAS_IN - BIAS_OUT + 1);
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
    localparam int LZW = $clog2(FW + 1);
`endif

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } cls_t;

    logic                    advance;
    logic                    handshake;
    logic                    s1_valid;
    logic                    s2_valid;

    logic [CHANNELS-1:0]     in_sign;
    logic [FLOAT_IN_EXP-1:0] in_exp  [CHANNELS];
    logic [FW-1:0]           in_frac [CHANNELS];
    cls_t                    in_cls  [CHANNELS];

    logic [CHANNELS-1:0]     s1_sign;
    logic [FLOAT_IN_EXP-1:0] s1_exp  [CHANNELS];
    logic [FW-1:0]           s1_frac [CHANNELS];
    cls_t                    s1_cls  [CHANNELS];

`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
    logic [LZW-1:0]          in_lzc  [CHANNELS];
    logic [LZW-1:0]          s1_lzc  [CHANNELS];
`endif

    logic [CHANNELS-1:0]     n_sign;
    cls_t                    n_cls   [CHANNELS];
    logic [EW-1:0]           n_exp   [CHANNELS];
    logic [FW-1:0]           n_frac  [CHANNELS];
    logic [CHANNELS-1:0]     n_ovf;
    logic [CHANNELS-1:0]     n_unf;
    logic [CHANNELS-1:0]     n_inv;
    logic [CHANNELS-1:0]     n_flush;

    logic [CHANNELS-1:0]     s2_flush;
    logic [3:0]              sticky;

    // The whole pipeline moves together: it advances when the output is free or being taken.
    assign advance        = i_aclken & ~i_areset & (~s2_valid | m_axis_tready);
    assign handshake      = s2_valid & m_axis_tready & i_aclken;
    assign s_axis_tready  = advance;
    assign m_axis_tvalid  = s2_valid;
    assign o_sticky_flags = sticky;

    // Split each incoming lane into its fields and classify it.
    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            in_sign[k] = s_axis_tdata[k*IW + IW - 1];
            in_exp[k]  = s_axis_tdata[k*IW + FW +: FLOAT_IN_EXP];
            in_frac[k] = s_axis_tdata[k*IW +: FW];
            in_cls[k]  = CLS_NORM;
            if (&in_exp[k]) begin
                if (in_frac[k] == '0)
                    in_cls[k] = CLS_INF;
                else if (in_frac[k][FW-1])
                    in_cls[k] = CLS_QNAN;
                else
                    in_cls[k] = CLS_SNAN;
            end else if (in_exp[k] == '0) begin
                in_cls[k] = (in_frac[k] == '0) ? CLS_ZERO : CLS_SUB;
            end
        end
    end

`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
    // Leading-zero count of the fraction. The highest set bit wins because it is assigned last.
    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            in_lzc[k] = LZW'(FW);
            for (int unsigned b = 0; b < FW; b++) begin
                if (in_frac[k][b])
                    in_lzc[k] = LZW'(FW - 1 - b);
            end
        end
    end
`endif

    // Stage 1 register: decoded lane fields and the stage-valid bit.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            s1_valid <= 1'b0;
            s1_sign  <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                s1_exp[k]  <= '0;
                s1_frac[k] <= '0;
                s1_cls[k]  <= CLS_ZERO;
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
                s1_lzc[k]  <= '0;
`endif
            end
        end else if (advance) begin
            s1_valid <= s_axis_tvalid;
            s1_sign  <= in_sign;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                s1_exp[k]  <= in_exp[k];
                s1_frac[k] <= in_frac[k];
                s1_cls[k]  <= in_cls[k];
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
                s1_lzc[k]  <= in_lzc[k];
`endif
            end
        end
    end

    // Per-class exponent/fraction shaping and the target-range flags.
    always_comb begin
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            n_sign[k]  = s1_sign[k];
            n_cls[k]   = s1_cls[k];
            n_exp[k]   = '0;
            n_frac[k]  = s1_frac[k];
            n_ovf[k]   = 1'b0;
            n_unf[k]   = 1'b0;
            n_inv[k]   = 1'b0;
            n_flush[k] = 1'b0;
            case (s1_cls[k])
                CLS_NORM: begin
                    n_exp[k] = EW'(s1_exp[k]) - EW'(BIAS_IN);
                    n_ovf[k] = FLAGS_EN & (32'(s1_exp[k]) > OVF_TH);
                    n_unf[k] = FLAGS_EN & (32'(s1_exp[k]) < UNF_TH);
                end
                CLS_SUB: begin
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
                    n_exp[k]  = EW'(1 - BIAS_IN) - EW'(s1_lzc[k]) - EW'(1);
                    n_frac[k] = (s1_frac[k] << s1_lzc[k]) << 1;
                    n_unf[k]  = FLAGS_EN;
`else
                    n_cls[k]   = CLS_ZERO;
                    n_frac[k]  = '0;
                    n_flush[k] = 1'b1;
`endif
                end
                CLS_QNAN: begin
                    n_sign[k] = 1'b0;
                end
                CLS_SNAN: begin
                    n_sign[k] = 1'b0;
                    n_inv[k]  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Stage 2 register: drives the output ports directly.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            s2_valid    <= 1'b0;
            m_sign      <= '0;
            m_class     <= '0;
            m_exp       <= '0;
            m_frac      <= '0;
            m_overflow  <= '0;
            m_underflow <= '0;
            m_invalid   <= '0;
            s2_flush    <= '0;
        end else if (advance) begin
            s2_valid    <= s1_valid;
            m_sign      <= n_sign;
            m_overflow  <= n_ovf;
            m_underflow <= n_unf;
            m_invalid   <= n_inv;
            s2_flush    <= n_flush;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                m_class[3*k +: 3]  <= n_cls[k];
                m_exp[k*EW +: EW]  <= n_exp[k];
                m_frac[k*FW +: FW] <= n_frac[k];
            end
        end
    end

    // Sticky {invalid, overflow, underflow, flush}. A beat taken in the same cycle as a clear still leaves its flags set.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            sticky <= '0;
        end else if (i_aclken) begin
            if (handshake)
                sticky <= (i_flag_clr ? 4'b0000 : sticky) |
                          {|m_invalid, |m_overflow, |m_underflow, |s2_flush};
            else if (i_flag_clr)
                sticky <= '0;
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_fl2fl_classify_v2_0.sv
// Bench for ipsxe_floating_point_fl2fl_classify_v2_0.
// The bench has two instances: one with the default parameters, and one with
// double-to-single parameters for the overflow/underflow flags.
// A value-level reference model feeds a scoreboard that checks every valid output cycle.
// Directed literal checks pin down both the model and the DUT.
module tb_ipsxe_floating_point_fl2fl_classify_v2_0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aclken = 1'b1;
    logic        flag_clr = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [1:0]  m_sign, m_overflow, m_underflow, m_invalid;
    logic [5:0]  m_class;
    logic [19:0] m_exp;
    logic [45:0] m_frac;
    logic [3:0]  o_sticky_flags;

    logic         b_tvalid = 1'b0;
    logic         b_tready;
    logic [127:0] b_tdata = '0;
    logic         b_mvalid;
    logic [1:0]   b_sign, b_ovf, b_unf, b_inv;
    logic [5:0]   b_class;
    logic [25:0]  b_exp;
    logic [103:0] b_frac;
    logic [3:0]   b_sticky;

    int checks = 0;
    int errors = 0;
    int delivered = 0;

    always #5 clk = ~clk;

    ipsxe_floating_point_fl2fl_classify_v2_0 #(
        .FLOAT_IN_EXP(8), .FLOAT_IN_FRAC(24), .FLOAT_OUT_EXP(11), .CHANNELS(2)
    ) dut (
        .i_aclk(clk), .i_areset(rst), .i_aclken(aclken),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_sign(m_sign), .m_class(m_class), .m_exp(m_exp), .m_frac(m_frac),
        .m_overflow(m_overflow), .m_underflow(m_underflow), .m_invalid(m_invalid),
        .i_flag_clr(flag_clr), .o_sticky_flags(o_sticky_flags)
    );

    ipsxe_floating_point_fl2fl_classify_v2_0 #(
        .FLOAT_IN_EXP(11), .FLOAT_IN_FRAC(53), .FLOAT_OUT_EXP(8), .CHANNELS(2)
    ) dut_b (
        .i_aclk(clk), .i_areset(rst), .i_aclken(1'b1),
        .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tdata(b_tdata),
        .m_axis_tvalid(b_mvalid), .m_axis_tready(1'b1),
        .m_sign(b_sign), .m_class(b_class), .m_exp(b_exp), .m_frac(b_frac),
        .m_overflow(b_ovf), .m_underflow(b_unf), .m_invalid(b_inv),
        .i_flag_clr(1'b0), .o_sticky_flags(b_sticky)
    );

    typedef struct {
        logic            sign;
        int              cls;
        int              exp;
        longint unsigned frac;
        logic            ovf, unf, inv, flush;
    } lane_t;

    typedef struct {
        logic [1:0]  sign;
        logic [5:0]  cls;
        logic [19:0] exp;
        logic [45:0] frac;
        logic [1:0]  ovf, unf, inv, flush;
    } beat_t;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Reference value model. It works from the real value of the operand
    // (true exponent, position of the leading one), not from field arithmetic.
    function automatic lane_t model(input logic [63:0] w, input int xe, input int xf, input int oe);
        lane_t r;
        int fw, e, bias, obias;
        longint unsigned fm, f;
        logic flg;
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
        int p;
`endif
        fw    = xf - 1;
        fm    = (64'd1 << fw) - 64'd1;
        f     = w & fm;
        e     = int'((w >> fw) & ((64'd1 << xe) - 64'd1));
        bias  = (1 << (xe - 1)) - 1;
        obias = (1 << (oe - 1)) - 1;
        flg   = (xe > oe);
        r.sign = w[xe + fw];
        r.cls = 2; r.exp = 0; r.frac = f;
        r.ovf = 0; r.unf = 0; r.inv = 0; r.flush = 0;
        if (e == (1 << xe) - 1) begin
            if (f == 0) r.cls = 3;
            else begin
                r.sign = 0;
                if (((f >> (fw - 1)) & 1) != 0) r.cls = 4;
                else begin r.cls = 5; r.inv = 1; end
            end
        end else if (e == 0) begin
            if (f == 0) r.cls = 0;
            else begin
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
                p = 0;
                for (int i = 0; i < fw; i++) if (((f >> i) & 1) != 0) p = i;
                r.cls  = 1;
                r.exp  = p - fw + 1 - bias;
                r.frac = (f << (fw - p)) & fm;
                r.unf  = flg;
`else
                r.cls = 0; r.frac = 0; r.flush = 1;
`endif
            end
        end else begin
            r.exp = e - bias;
            r.ovf = flg && (e - bias > obias);
            r.unf = flg && (e - bias < 1 - obias);
        end
        return r;
    endfunction

    function automatic beat_t model_beat(input logic [63:0] d);
        beat_t b;
        lane_t r;
        for (int k = 0; k < 2; k++) begin
            r = model({32'd0, d[k*32 +: 32]}, 8, 24, 11);
            b.sign[k]         = r.sign;
            b.cls[k*3 +: 3]   = 3'(r.cls);
            b.exp[k*10 +: 10] = 10'(r.exp);
            b.frac[k*23 +: 23] = 23'(r.frac);
            b.ovf[k]   = r.ovf;
            b.unf[k]   = r.unf;
            b.inv[k]   = r.inv;
            b.flush[k] = r.flush;
        end
        return b;
    endfunction

    beat_t      q[$];
    beat_t      sb_exp;
    logic [3:0] msticky = 4'd0;

    // Scoreboard: checks each valid output cycle against the oldest outstanding beat, and tracks sticky flags.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            msticky = 4'd0;
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_s_tready", s_axis_tready, 0);
        end else begin
            chk("sticky", o_sticky_flags, msticky);
            if (!aclken) chk("gated_s_tready", s_axis_tready, 0);
            if (m_axis_tvalid && !m_axis_tready) chk("stall_s_tready", s_axis_tready, 0);
            if (m_axis_tvalid && q.size() == 0) begin
                chk("spurious_tvalid", m_axis_tvalid, 0);
            end else if (m_axis_tvalid) begin
                sb_exp = q[0];
                chk("sb_sign", m_sign, sb_exp.sign);
                chk("sb_class", m_class, sb_exp.cls);
                chk("sb_exp", m_exp, sb_exp.exp);
                chk("sb_frac", m_frac, sb_exp.frac);
                chk("sb_ovf", m_overflow, sb_exp.ovf);
                chk("sb_unf", m_underflow, sb_exp.unf);
                chk("sb_inv", m_invalid, sb_exp.inv);
                if (m_axis_tready && aclken) begin
                    msticky = (flag_clr ? 4'd0 : msticky) |
                              {|sb_exp.inv, |sb_exp.ovf, |sb_exp.unf, |sb_exp.flush};
                    void'(q.pop_front());
                    delivered++;
                end else if (flag_clr && aclken) begin
                    msticky = 4'd0;
                end
            end else if (flag_clr && aclken) begin
                msticky = 4'd0;
            end
            if (s_axis_tvalid && s_axis_tready) q.push_back(model_beat(s_axis_tdata));
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [63:0] d);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        @(negedge clk);
        while (!s_axis_tready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", s_axis_tready, 1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    logic [63:0] stream [10];
    lane_t       pin;
    int          base;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        stream[0] = {32'hC0490FDB, 32'h3F800000};
        stream[1] = {32'h80000001, 32'h00400000};
        stream[2] = {32'h80000000, 32'h7F800000};
        stream[3] = {32'h7F800002, 32'h7FC00001};
        stream[4] = {32'h7F7FFFFF, 32'h00800000};
        stream[5] = {32'hBF800000, 32'h40000000};
        stream[6] = {32'h3EAAAAAB, 32'h007FFFFF};
        stream[7] = {32'h9ABCDEF0, 32'h12345678};
        stream[8] = {32'h00000000, 32'hFFC00000};
        stream[9] = {32'hC1200000, 32'h41200000};

        // Hand-computed values that pin the reference model.
        pin = model(64'h3F800000, 8, 24, 11);
        chk("pin_one_cls", 32'(pin.cls), 32'd2);
        chk("pin_one_exp", 32'(pin.exp), 32'd0);
        pin = model(64'hFF800001, 8, 24, 11);
        chk("pin_snan", {pin.sign, pin.inv, 3'(pin.cls)}, {1'b0, 1'b1, 3'd5});
        pin = model(64'h47F0000000000000, 11, 53, 8);
        chk("pin_b_ovf", {pin.ovf, pin.unf, 32'(pin.exp)}, {1'b1, 1'b0, 32'd128});
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
        pin = model(64'h00400000, 8, 24, 11);
        chk("pin_sub_exp", 32'(pin.exp), 32'hFFFFFF81);
        chk("pin_sub_frac", pin.frac, 0);
`else
        pin = model(64'h00400000, 8, 24, 11);
        chk("pin_flush", {pin.flush, 3'(pin.cls)}, {1'b1, 3'd0});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_class", m_class, 0);
        chk("rst_sticky", o_sticky_flags, 0);
        chk("rst_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("tready_after_rst", s_axis_tready, 1);
        @(posedge clk); #1;

        // Test 1: 1.0 and -inf
        send_beat({32'hFF800000, 32'h3F800000});
        chk("lat_early", m_axis_tvalid, 0);
        @(posedge clk); #1;
        chk("lat_2", m_axis_tvalid, 1);
        chk("t1_class", m_class, {3'd3, 3'd2});
        chk("t1_sign", m_sign, 2'b10);
        chk("t1_exp", m_exp, 0);
        chk("t1_frac", m_frac, 0);
        chk("t1_flags", {m_overflow, m_underflow, m_invalid}, 0);
        @(posedge clk); #1;
        chk("t1_done", m_axis_tvalid, 0);
        chk("t1_sticky", o_sticky_flags, 0);

        // Test 2: qnan and snan, then clear the sticky flags
        send_beat({32'hFF800001, 32'h7FC00000});
        @(posedge clk); #1;
        chk("t2_class", m_class, {3'd5, 3'd4});
        chk("t2_sign", m_sign, 2'b00);
        chk("t2_inv", m_invalid, 2'b10);
        @(posedge clk); #1;
        chk("t2_sticky", o_sticky_flags, 4'b1000);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("t2_clear", o_sticky_flags, 4'b0000);

        // Test 3: smallest subnormal in lane 0
        send_beat({32'h00000000, 32'h00000001});
        @(posedge clk); #1;
`ifdef IPSXE_FLT_FL2FL_SUBNORM_EN
        chk("t3_class", m_class, {3'd0, 3'd1});
        chk("t3_exp", m_exp, 20'h0036B);
        chk("t3_frac", m_frac, 0);
        @(posedge clk); #1;
        chk("t3_sticky", o_sticky_flags, 4'b0000);
`else
        chk("t3_class", m_class, 0);
        chk("t3_exp", m_exp, 0);
        chk("t3_unf", m_underflow, 0);
        @(posedge clk); #1;
        chk("t3_sticky", o_sticky_flags, 4'b0001);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
`endif

        // Stream of ten beats with backpressure and a clock-enable gap
        base = delivered;
        fork
            begin
                for (int i = 0; i < 10; i++) send_beat(stream[i]);
            end
            begin
                for (int c = 0; c < 45; c++) begin
                    m_axis_tready = (c % 3 == 0);
                    aclken = !(c == 7 || c == 8);
                    @(posedge clk); #1;
                end
            end
        join
        m_axis_tready = 1'b1;
        aclken = 1'b1;
        drain();
        chk("stream_count", delivered - base, 10);

        // Reset with two beats in flight
        m_axis_tready = 1'b0;
        send_beat(stream[0]);
        send_beat(stream[5]);
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_class", m_class, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk("postrst_idle", m_axis_tvalid, 0);
        end
        base = delivered;
        send_beat(stream[9]);
        drain();
        chk("postrst_count", delivered - base, 1);

        // Wider-input instance: target overflow and underflow
        chk("b_tready", b_tready, 1);
        b_tvalid = 1'b1;
        b_tdata  = {64'h3800000000000000, 64'h47F0000000000000};
        @(posedge clk); #1;
        b_tvalid = 1'b0;
        @(posedge clk); #1;
        chk("b_tvalid", b_mvalid, 1);
        chk("b_ovf", b_ovf, 2'b01);
        chk("b_unf", b_unf, 2'b10);
        chk("b_class", b_class, {3'd2, 3'd2});
        chk("b_exp", b_exp, {13'h1F81, 13'h0080});
        chk("b_misc", {b_sign, b_inv, b_frac}, 0);
        @(posedge clk); #1;
        chk("b_sticky", b_sticky, 4'b0110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
